corr_window_engine: RTL and testbench
=====================================

Name: corr_window_engine

Overview:
- Upstream neighbour of the correlation-search controller.
- For each start coordinate (iX, iY) the controller issues, it reads a TPL_W x TPL_H window from the saved frame buffer and the stored template.
- It accumulates the sum of absolute differences (SAD) over the window and returns a 16-bit similarity score (bigger = better match) with a one-cycle finished pulse.

Parameters:
- H_RES, 640, frame width in pixels
- V_RES, 480, frame height in pixels
- TPL_W, 16, template width
- TPL_H, 16, template height
- PIX_W, 8, grey pixel width
- FADDR_W, 19, frame buffer address width
- TADDR_W, 8, template memory address width

Ports:
- iCLK  in  1  system clock (50 MHz)
- iRST  in  1  reset; synchronous, active-low
- iStart  in  1  start pulse; sampled only when oReady=1
- iX  in  13  window start X, latched on accepted start
- iY  in  13  window start Y, latched on accepted start
- oReady  out  1  high in IDLE only
- oFrameAddr  out  FADDR_W  frame read address = y*H_RES + x
- oFrameRd  out  1  frame read strobe
- iFrameData  in  PIX_W  frame pixel, valid 1 cycle after oFrameRd
- oTplAddr  out  TADDR_W  template address = row*TPL_W + col
- iTplData  in  PIX_W  template pixel, valid 1 cycle after oTplAddr is presented with oFrameRd=1
- oCorr  out  16  score = 16'hFFFF - sat16(SAD); held until next finish
- oCorrFinished  out  1  one-cycle pulse; oCorr valid in the same cycle

Behaviour:
- Reset (iRST=0 at a clock edge):
  - state IDLE; oReady=1.
  - oCorr, oCorrFinished, oFrameRd, oFrameAddr and oTplAddr all 0.
  - Accumulator and row/col counters 0.
  - Applies mid-operation: any window in progress is abandoned and no finished pulse is produced.
- FSM states:
  - IDLE:
    - iStart=1 latches iX, iY, clears accumulator and col/row, then goes to RUN.
    - iStart is ignored in every other state.
  - RUN:
    - Each cycle: present addresses for (col,row), assert oFrameRd, then advance col.
    - col wraps TPL_W-1 -> 0 with row+1.
    - After issuing (TPL_W-1, TPL_H-1), go to DRAIN.
  - DRAIN: one cycle; accumulates the last returned pixel pair; go to DONE.
  - DONE: oCorrFinished=1 and oCorr updated; go to IDLE.
- Latency:
  - N = TPL_W*TPL_H.
  - Start accepted at edge 0; reads issued cycles 1..N; data accumulated at edges 2..N+1.
  - oCorrFinished high in cycle N+2. For 16x16 that is cycle 258.
  - The next start is accepted no earlier than cycle N+3.
- Arithmetic:
  - Per pair, |f - t| is computed at PIX_W bits, unsigned.
  - Accumulator is PIX_W + clog2(N) + 1 bits wide.
  - sat16 clamps to 16'hFFFF.
- Out-of-frame pixels:
  - A pixel is out of frame when iX+col >= H_RES or iY+row >= V_RES.
  - For such pixels oFrameRd=0 and oFrameAddr is held, and the frame pixel is treated as 0 for that pair.
  - A one-cycle-delayed valid bit tracks which returned pairs are substituted.
- Coordinate arithmetic is 14 bits wide; no wrap into the next line is allowed.
- oTplAddr always advances regardless of clipping.

Optional Feature:
- Macro: CORR_SAT_FLAG_EN.
- When defined, an extra output oCorrSat (1 bit) is added:
  - Reset 0.
  - Updated with oCorr in DONE; 1 when SAD exceeded 16'hFFFF, i.e. oCorr was forced to 0.
- When not defined, the port is absent and saturation is silent.

Decomposition:
- Shared package corr_pkg holds:
  - FSM state enum (IDLE, RUN, DRAIN, DONE);
  - score width constant CORR_W=16;
  - the accumulator-width function;
  - saturation constant 16'hFFFF.
  - The same package is imported by the controller.
- One natural sub-module: corr_addr_gen.
  - Contains the col/row counters, clipping compare, address multiply-add and the last-pixel flag.
  - The engine keeps the FSM, the valid pipeline and the accumulator.

Test Plan:
- Identical frame and template (both all 0x80), start (0,0) -> oCorrFinished in cycle 258, oCorr=16'hFFFF.
- Frame all 0x00, template all 0x01 -> SAD=256, oCorr=16'hFEFF.
- Frame all 0x00, template all 0xFF -> SAD=65280, oCorr=16'h00FF.
  - Same case with TPL_W=TPL_H=32 -> oCorr=0; oCorrSat=1 when CORR_SAT_FLAG_EN.
- Start (632,0) with 640-wide frame, frame all 0x10, template all 0x10:
  - only 8 columns read per row; 128 reads total, addresses never beyond x=639.
  - Clipped pairs contribute 0x10 each -> SAD=2048, oCorr=16'hF7FF.
- iStart pulsed during RUN at cycle 100 -> ignored, single finished pulse at 258.
  - Second start at cycle 259 is accepted and finishes at cycle 517.
- iRST=0 asserted at cycle 50 of a window:
  - next cycle oReady=1, all outputs 0, no oCorrFinished pulse.
  - A fresh start afterwards produces a correct score.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared definitions for the correlation window engine and its controller.
//   corr_state_t : engine FSM states (IDLE, RUN, DRAIN, DONE)
//   CORR_W       : width of the similarity score
//   CORR_SAT     : value at which the SAD is clamped before inversion
//   acc_width()  : SAD accumulator width for a given pixel width / pair count
package corr_pkg;

    localparam int CORR_W = 16;
    localparam logic [CORR_W-1:0] CORR_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } corr_state_t;

    // One guard bit above the exact worst-case sum of n PIX_W-bit differences.
    function automatic int acc_width(input int pix_w, input int n);
        return pix_w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/corr_addr_gen.sv
// Window read address generator for corr_window_engine.
// Walks (col,row) over the TPL_W x TPL_H template, producing registered frame
// and template addresses plus a frame read strobe that is suppressed for
// pixels falling right of or below the frame edge.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   load            : start of window; latches x/y and issues pair (0,0)
//   step            : issue the next pair of the current window
//   x, y            : window start coordinate (used when load=1)
//   frame_addr      : y*H_RES + x of the issued pixel (held when clipped)
//   frame_rd        : frame read strobe for the issued pixel
//   tpl_addr        : row*TPL_W + col, advances even for clipped pixels
//   last            : high while the final pair of the window is presented
module corr_addr_gen
    import corr_pkg::*;
#(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int TPL_W   = 16,
    parameter int TPL_H   = 16,
    parameter int FADDR_W = 19,
    parameter int TADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [12:0]        x,
    input  logic [12:0]        y,
    output logic [FADDR_W-1:0] frame_addr,
    output logic               frame_rd,
    output logic [TADDR_W-1:0] tpl_addr,
    output logic               last
);

    localparam int CW = $clog2(TPL_W);
    localparam int RW = $clog2(TPL_H);

    logic [12:0]        base_x;
    logic [12:0]        base_y;
    logic [CW-1:0]      col;
    logic [RW-1:0]      row;

    logic [12:0]        cur_x;
    logic [12:0]        cur_y;
    logic [CW-1:0]      cur_col;
    logic [RW-1:0]      cur_row;
    logic [13:0]        px;
    logic [13:0]        py;
    logic               in_frame;
    logic               last_pair;
    logic               col_wrap;
    logic [FADDR_W-1:0] lin_addr;
    logic [TADDR_W-1:0] tpl_lin;

    // On load the first pair is issued straight from the start inputs so the
    // first read appears in the cycle right after the start is accepted; the
    // counters therefore always hold the next pair to issue.
    always_comb begin
        cur_x     = load ? x : base_x;
        cur_y     = load ? y : base_y;
        cur_col   = load ? '0 : col;
        cur_row   = load ? '0 : row;
        px        = {1'b0, cur_x} + 14'(cur_col);
        py        = {1'b0, cur_y} + 14'(cur_row);
        in_frame  = (px < 14'(H_RES)) && (py < 14'(V_RES));
        col_wrap  = (cur_col == CW'(TPL_W - 1));
        last_pair = col_wrap && (cur_row == RW'(TPL_H - 1));
        lin_addr  = FADDR_W'(py) * FADDR_W'(H_RES) + FADDR_W'(px);
        tpl_lin   = TADDR_W'(cur_row) * TADDR_W'(TPL_W) + TADDR_W'(cur_col);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_x     <= '0;
            base_y     <= '0;
            col        <= '0;
            row        <= '0;
            frame_addr <= '0;
            frame_rd   <= 1'b0;
            tpl_addr   <= '0;
            last       <= 1'b0;
        end else begin
            frame_rd <= 1'b0;
            last     <= 1'b0;
            if (load || step) begin
                if (load) begin
                    base_x <= x;
                    base_y <= y;
                end
                frame_rd <= in_frame;
                if (in_frame) begin
                    frame_addr <= lin_addr;
                end
                tpl_addr <= tpl_lin;
                last     <= last_pair;
                if (col_wrap) begin
                    col <= '0;
                    row <= cur_row + RW'(1);
                end else begin
                    col <= cur_col + CW'(1);
                    row <= cur_row;
                end
            end
        end
    end

endmodule

// File: rtl/corr_window_engine.sv
// Correlation window engine: for each accepted start (iX,iY) reads a
// TPL_W x TPL_H window of the frame and the template, accumulates the sum of
// absolute differences and reports 16'hFFFF - sat16(SAD) with a one-cycle
// oCorrFinished pulse. Pixels outside the frame read as 0 without a frame
// access.
// Optional feature macro: CORR_SAT_FLAG_EN adds oCorrSat (SAD saturated).
// Ports:
//   iCLK, iRST       : clock, synchronous active-low reset
//   iStart, iX, iY   : window start request, accepted only while oReady=1
//   oReady           : engine idle
//   oFrameAddr/oFrameRd, iFrameData : frame buffer read port (1-cycle latency)
//   oTplAddr, iTplData               : template read port (1-cycle latency)
//   oCorr, oCorrFinished             : score and its completion pulse
//   oCorrSat (optional)              : score was forced to 0 by saturation
module corr_window_engine
    import corr_pkg::*;
#(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int TPL_W   = 16,
    parameter int TPL_H   = 16,
    parameter int PIX_W   = 8,
    parameter int FADDR_W = 19,
    parameter int TADDR_W = 8
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iStart,
    input  logic [12:0]        iX,
    input  logic [12:0]        iY,
    output logic               oReady,
    output logic [FADDR_W-1:0] oFrameAddr,
    output logic               oFrameRd,
    input  logic [PIX_W-1:0]   iFrameData,
    output logic [TADDR_W-1:0] oTplAddr,
    input  logic [PIX_W-1:0]   iTplData,
    output logic [CORR_W-1:0]  oCorr,
    output logic               oCorrFinished
`ifdef CORR_SAT_FLAG_EN
    ,
    output logic               oCorrSat
`endif
);

    localparam int ACC_W = acc_width(PIX_W, TPL_W * TPL_H);
    localparam int CMP_W = (ACC_W > CORR_W) ? ACC_W : CORR_W;

    corr_state_t       state;
    logic              load;
    logic              step;
    logic              last;
    logic              acc_vld;
    logic              acc_inb;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [PIX_W-1:0]  frame_pix;
    logic [PIX_W-1:0]  abs_diff;
    logic [CMP_W-1:0]  acc_ext;
    logic              over;
    logic [CORR_W-1:0] sad16;

    corr_addr_gen #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .TPL_W  (TPL_W),
        .TPL_H  (TPL_H),
        .FADDR_W(FADDR_W),
        .TADDR_W(TADDR_W)
    ) u_addr_gen (
        .clk       (iCLK),
        .rst_n     (iRST),
        .load      (load),
        .step      (step),
        .x         (iX),
        .y         (iY),
        .frame_addr(oFrameAddr),
        .frame_rd  (oFrameRd),
        .tpl_addr  (oTplAddr),
        .last      (last)
    );

    // acc_vld/acc_inb trail the presented pair by one cycle so they line up
    // with the returned data; clipped pairs substitute a 0 frame pixel.
    always_comb begin
        load      = (state == IDLE) && iStart;
        step      = (state == RUN) && !last;
        frame_pix = acc_inb ? iFrameData : '0;
        abs_diff  = (frame_pix >= iTplData) ? (frame_pix - iTplData)
                                            : (iTplData - frame_pix);
        acc_next  = acc_vld ? (acc + ACC_W'(abs_diff)) : acc;
        acc_ext   = CMP_W'(acc_next);
        over      = acc_ext > CMP_W'(CORR_SAT);
        sad16     = over ? CORR_SAT : acc_ext[CORR_W-1:0];
    end

    // The score is taken from acc_next in DRAIN so the last pair, returned
    // in that same cycle, is included and the pulse lands in DONE.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state         <= IDLE;
            oReady        <= 1'b1;
            oCorr         <= '0;
            oCorrFinished <= 1'b0;
            acc_vld       <= 1'b0;
            acc_inb       <= 1'b0;
            acc           <= '0;
`ifdef CORR_SAT_FLAG_EN
            oCorrSat      <= 1'b0;
`endif
        end else begin
            oCorrFinished <= 1'b0;
            acc_vld       <= (state == RUN);
            acc_inb       <= oFrameRd;
            acc           <= acc_next;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        acc    <= '0;
                        oReady <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    oCorr         <= CORR_SAT - sad16;
                    oCorrFinished <= 1'b1;
`ifdef CORR_SAT_FLAG_EN
                    oCorrSat      <= over;
`endif
                    state         <= DONE;
                end
                DONE: begin
                    oReady <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    oReady <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corr_window_engine.sv
// Self-checking bench for corr_window_engine (16x16 instance plus a 32x32
// instance for saturation). A timeline model derived from the window rules
// predicts every output each cycle; literal values pin the model.
// Honours CORR_SAT_FLAG_EN when defined.
module tb_corr_window_engine;

    localparam int HR = 640;
    localparam int VR = 480;
    localparam int W  = 16;
    localparam int H  = 16;
    localparam int N  = W * H;

    logic        clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [12:0] sx;
    logic [12:0] sy;
    logic        ready;
    logic        frd;
    logic        fin;
    logic [18:0] faddr;
    logic [7:0]  taddr;
    logic [7:0]  fdata;
    logic [7:0]  tdata;
    logic [15:0] corr;

    logic        big_start;
    logic        big_ready;
    logic        big_frd;
    logic        big_fin;
    logic [18:0] big_faddr;
    logic [9:0]  big_taddr;
    logic [15:0] big_corr;
`ifdef CORR_SAT_FLAG_EN
    logic        csat;
    logic        big_sat;
`endif

    corr_window_engine #(
        .H_RES(640), .V_RES(480), .TPL_W(16), .TPL_H(16),
        .PIX_W(8), .FADDR_W(19), .TADDR_W(8)
    ) dut (
        .iCLK(clk), .iRST(rst_n), .iStart(start), .iX(sx), .iY(sy),
        .oReady(ready), .oFrameAddr(faddr), .oFrameRd(frd),
        .iFrameData(fdata), .oTplAddr(taddr), .iTplData(tdata),
        .oCorr(corr), .oCorrFinished(fin)
`ifdef CORR_SAT_FLAG_EN
        , .oCorrSat(csat)
`endif
    );

    corr_window_engine #(
        .H_RES(640), .V_RES(480), .TPL_W(32), .TPL_H(32),
        .PIX_W(8), .FADDR_W(19), .TADDR_W(10)
    ) big (
        .iCLK(clk), .iRST(rst_n), .iStart(big_start), .iX(13'd0), .iY(13'd0),
        .oReady(big_ready), .oFrameAddr(big_faddr), .oFrameRd(big_frd),
        .iFrameData(8'h00), .oTplAddr(big_taddr), .iTplData(8'hFF),
        .oCorr(big_corr), .oCorrFinished(big_fin)
`ifdef CORR_SAT_FLAG_EN
        , .oCorrSat(big_sat)
`endif
    );

    // Memories: frame is a function of address, template an array.
    logic [7:0] tpl [N];
    int         fmode;
    logic [7:0] fconst;

    function automatic logic [7:0] frame_pix(input int a);
        if (fmode == 0) return fconst;
        return 8'((a * 37) ^ (a >> 9));
    endfunction

    always @(posedge clk) begin
        tdata <= tpl[taddr];
        fdata <= frd ? frame_pix(int'(faddr)) : 8'hA5;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: window SAD from plain arithmetic, output timeline
    // from the stated latencies (pair k shown k cycles after accept, pulse at
    // N+1, idle again at N+2).
    int          busy, t, wx, wy, win_sad;
    logic [15:0] win_corr, m_corr;
    logic        win_sat, m_sat, m_fin, m_rd;
    logic [18:0] m_faddr;
    logic [7:0]  m_taddr;

    function automatic int sad_of(input int x, input int y);
        int s = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                int f = 0;
                int p = int'(tpl[r * W + c]);
                if (x + c < HR && y + r < VR) f = int'(frame_pix((y + r) * HR + x + c));
                s += (f > p) ? f - p : p - f;
            end
        return s;
    endfunction

    task automatic set_pair(input int k);
        int c = k % W;
        int r = k / W;
        m_taddr = 8'(k);
        m_rd = (wx + c < HR) && (wy + r < VR);
        if (m_rd) m_faddr = 19'((wy + r) * HR + wx + c);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            busy = 0; t = 0; m_corr = '0; m_sat = 1'b0; m_fin = 1'b0;
            m_rd = 1'b0; m_faddr = '0; m_taddr = '0;
        end else begin
            m_fin = 1'b0;
            m_rd  = 1'b0;
            if (busy != 0) begin
                t++;
                if (t < N) set_pair(t);
                if (t == N + 1) begin
                    m_fin = 1'b1; m_corr = win_corr; m_sat = win_sat;
                end
                if (t == N + 2) busy = 0;
            end else if (start) begin
                busy = 1; t = 0; wx = int'(sx); wy = int'(sy);
                win_sad  = sad_of(wx, wy);
                win_sat  = win_sad > 65535;
                win_corr = win_sat ? 16'h0000 : 16'(65535 - win_sad);
                set_pair(0);
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int chk_en = 0;
    int fin_cnt = 0;
    int nreads = 0;
    int nwrap = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Every bench wait goes through here: one cycle, then the per-cycle
    // comparison of all outputs against the model.
    task automatic tick();
        @(negedge clk);
        if (chk_en != 0) begin
            chk("ready", 32'(ready), 32'(busy == 0));
            chk("fin",   32'(fin),   32'(m_fin));
            chk("frd",   32'(frd),   32'(m_rd));
            chk("faddr", 32'(faddr), 32'(m_faddr));
            chk("taddr", 32'(taddr), 32'(m_taddr));
            chk("corr",  32'(corr),  32'(m_corr));
`ifdef CORR_SAT_FLAG_EN
            chk("sat",   32'(csat),  32'(m_sat));
`endif
        end
        if (fin) fin_cnt++;
        if (frd) begin
            nreads++;
            if (int'(faddr) % HR < int'(sx)) nwrap++;
        end
    endtask

    task automatic wait_fin(input int acc_cyc, output int lat);
        lat = -1;
        for (int i = 0; i < 2000 && lat < 0; i++) begin
            tick();
            if (fin) lat = cyc - acc_cyc;
        end
    endtask

    task automatic run_win(input int x, input int y, input int lit, input logic [15:0] want,
                           input string nm);
        int e, lat;
        chk({nm, "_ready"}, 32'(ready), 32'd1);
        sx = 13'(x); sy = 13'(y); start = 1'b1;
        tick();
        e = cyc; start = 1'b0;
        wait_fin(e, lat);
        chk({nm, "_lat"}, 32'(lat), 32'd257);
        if (lit != 0) begin
            chk({nm, "_corr"}, 32'(corr), 32'(want));
            chk({nm, "_model"}, 32'(win_corr), 32'(want));
        end
        tick();
    endtask

    task automatic fill_tpl(input int mode, input logic [7:0] v);
        for (int k = 0; k < N; k++) tpl[k] = (mode == 0) ? v : 8'(k * 5);
    endtask

    initial begin
        int e, lat, r0, f0;
        rst_n = 1'b0; start = 1'b0; big_start = 1'b0; sx = '0; sy = '0;
        fmode = 0; fconst = 8'h00; fill_tpl(0, 8'h00);
        tick(); tick();
        chk_en = 1;
        tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_corr",  32'(corr),  32'd0);
        chk("rst_frd",   32'(frd),   32'd0);
        chk("rst_faddr", 32'(faddr), 32'd0);
        chk("rst_taddr", 32'(taddr), 32'd0);
        chk("rst_fin",   32'(fin),   32'd0);
        rst_n = 1'b1;
        tick();

        fconst = 8'h80; fill_tpl(0, 8'h80);
        run_win(0, 0, 1, 16'hFFFF, "same");
        fconst = 8'h00; fill_tpl(0, 8'h01);
        run_win(0, 0, 1, 16'hFEFF, "one");
        fill_tpl(0, 8'hFF);
        run_win(0, 0, 1, 16'h00FF, "ff");

        fconst = 8'h10; fill_tpl(0, 8'h10);
        r0 = nreads; f0 = nwrap;
        run_win(632, 0, 1, 16'hF7FF, "clipx");
        chk("clipx_reads", 32'(nreads - r0), 32'd128);
        chk("clipx_wrap",  32'(nwrap - f0),  32'd0);

        fmode = 1; fill_tpl(1, 8'h00);
        run_win(100, 200, 0, 16'h0000, "pat_mid");
        run_win(630, 470, 0, 16'h0000, "pat_corner");

        // Start during RUN is ignored; back-to-back start at the first ready cycle.
        fmode = 0; fconst = 8'h00; fill_tpl(0, 8'h01);
        sx = '0; sy = '0; start = 1'b1;
        tick();
        e = cyc; start = 1'b0; f0 = fin_cnt;
        while (cyc < e + 99) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_fin(e, lat);
        chk("ign_lat", 32'(lat), 32'd257);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("b2b_accept", 32'(cyc - e), 32'd259);
        wait_fin(e, lat);
        chk("b2b_fin", 32'(lat), 32'd516);
        chk("b2b_corr", 32'(corr), 32'hFEFF);
        chk("pulses", 32'(fin_cnt - f0), 32'd2);
        tick();

        // Reset mid-window.
        fill_tpl(0, 8'hFF);
        start = 1'b1; tick();
        e = cyc; start = 1'b0;
        while (cyc < e + 49) tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_ready", 32'(ready), 32'd1);
        chk("mrst_corr",  32'(corr),  32'd0);
        chk("mrst_frd",   32'(frd),   32'd0);
        chk("mrst_faddr", 32'(faddr), 32'd0);
        chk("mrst_taddr", 32'(taddr), 32'd0);
        rst_n = 1'b1;
        f0 = fin_cnt;
        for (int i = 0; i < 300; i++) tick();
        chk("mrst_nopulse", 32'(fin_cnt - f0), 32'd0);
        run_win(0, 0, 1, 16'h00FF, "fresh");

        // 32x32 instance saturates.
        big_start = 1'b1; tick();
        e = cyc; big_start = 1'b0;
        lat = -1;
        for (int i = 0; i < 1500 && lat < 0; i++) begin
            tick();
            if (big_fin) lat = cyc - e;
        end
        chk("big_lat",  32'(lat),      32'd1025);
        chk("big_corr", 32'(big_corr), 32'd0);
`ifdef CORR_SAT_FLAG_EN
        chk("big_sat",  32'(big_sat),  32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
